// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard logic
package pipeline_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      ERROR    = 2'b10
   } hz_state_t;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // x0 is hardwired to zero, so it never produces a real dependency.
   function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd);
      return (rs != 5'd0) && (rs == rd);
   endfunction

endpackage

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - E-stage operand bypass select for one source register
module forwarding_unit
   import pipeline_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output fwd_sel_t   sel
);

   // M holds the younger result, so it wins over W.
   always_comb begin
      sel = FWD_RF;
      if (reg_write_m && reg_match(rs, rd_m))
         sel = FWD_M;
      else if (reg_write_w && reg_match(rs, rd_w))
         sel = FWD_W;
   end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/forward control, memory-wait FSM and perf counters
module hazard_controller
   import pipeline_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  logic [4:0]       rd_m,
   input  logic [4:0]       rd_w,
   input  logic [1:0]       result_src_e,
   input  logic             reg_write_m,
   input  logic             reg_write_w,
   input  logic             pc_src_e,
   input  logic             dmem_req_m,
   input  logic             dmem_ready,
   output logic [1:0]       forward_a_e,
   output logic [1:0]       forward_b_e,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   hz_state_t   state, state_nxt;
   logic [31:0] wait_cnt, wait_cnt_nxt;
   logic        timeout_set;
   logic        lw_stall, mem_stall, branch_taken;
   fwd_sel_t    fwd_a, fwd_b;

   forwarding_unit u_fwd_a (
      .rs          (rs1_e),
      .rd_m        (rd_m),
      .rd_w        (rd_w),
      .reg_write_m (reg_write_m),
      .reg_write_w (reg_write_w),
      .sel         (fwd_a)
   );

   forwarding_unit u_fwd_b (
      .rs          (rs2_e),
      .rd_m        (rd_m),
      .rd_w        (rd_w),
      .reg_write_m (reg_write_m),
      .reg_write_w (reg_write_w),
      .sel         (fwd_b)
   );

   assign forward_a_e = reset_n ? fwd_a : FWD_RF;
   assign forward_b_e = reset_n ? fwd_b : FWD_RF;

   assign lw_stall  = (result_src_e == RESULT_SRC_LOAD) &&
                      (reg_match(rs1_d, rd_e) || reg_match(rs2_d, rd_e));
   assign mem_stall = dmem_req_m && !dmem_ready;

   // A memory wait freezes the whole front end; branch and load-use are
   // simply re-evaluated once the access completes.
   always_comb begin
      stall_f      = 1'b0;
      stall_d      = 1'b0;
      stall_e      = 1'b0;
      stall_m      = 1'b0;
      flush_d      = 1'b0;
      flush_e      = 1'b0;
      flush_w      = 1'b0;
      branch_taken = 1'b0;
      if (!reset_n) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
         flush_w = 1'b1;
      end else if (state == ERROR || mem_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (pc_src_e) begin
         flush_d      = 1'b1;
         flush_e      = 1'b1;
         branch_taken = 1'b1;
      end else if (lw_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_set  = 1'b0;
      case (state)
         RUN: begin
            if (mem_stall) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 32'd1;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready || !dmem_req_m) begin
               state_nxt    = RUN;
               wait_cnt_nxt = 32'd0;
            end else begin
               wait_cnt_nxt = wait_cnt + 32'd1;
               if (MEM_TIMEOUT != 0 && wait_cnt == 32'(MEM_TIMEOUT - 1)) begin
                  state_nxt   = ERROR;
                  timeout_set = 1'b1;
               end
            end
         end
         ERROR:   state_nxt = ERROR;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= RUN;
         wait_cnt     <= 32'd0;
         mem_timeout  <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         mem_timeout <= mem_timeout | timeout_set;
         if (stall_f && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (branch_taken && flush_count != '1)
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed vector bench for hazard_controller
module tb_hazard_controller;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic [1:0]       result_src_e;
   logic             reg_write_m, reg_write_w, pc_src_e, dmem_req_m, dmem_ready;
   logic [1:0]       forward_a_e, forward_b_e;
   logic             stall_f, stall_d, stall_e, stall_m;
   logic             flush_d, flush_e, flush_w, mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rs1_d        (rs1_d),
      .rs2_d        (rs2_d),
      .rs1_e        (rs1_e),
      .rs2_e        (rs2_e),
      .rd_e         (rd_e),
      .rd_m         (rd_m),
      .rd_w         (rd_w),
      .result_src_e (result_src_e),
      .reg_write_m  (reg_write_m),
      .reg_write_w  (reg_write_w),
      .pc_src_e     (pc_src_e),
      .dmem_req_m   (dmem_req_m),
      .dmem_ready   (dmem_ready),
      .forward_a_e  (forward_a_e),
      .forward_b_e  (forward_b_e),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .stall_e      (stall_e),
      .stall_m      (stall_m),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .flush_w      (flush_w),
      .mem_timeout  (mem_timeout),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   typedef struct {
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
      logic [1:0] res;
      logic       rwm, rww, pc, req, rdy;
      logic [1:0] fa, fb;
      logic [3:0] st;
      logic [2:0] fl;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(
      input logic [4:0] a_rs1_d, a_rs2_d, a_rs1_e, a_rs2_e, a_rd_e, a_rd_m, a_rd_w,
      input logic [1:0] a_res,
      input logic a_rwm, a_rww, a_pc, a_req, a_rdy,
      input logic [1:0] a_fa, a_fb,
      input logic [3:0] a_st,
      input logic [2:0] a_fl);
      vec_t v;
      v.rs1_d = a_rs1_d; v.rs2_d = a_rs2_d; v.rs1_e = a_rs1_e; v.rs2_e = a_rs2_e;
      v.rd_e = a_rd_e; v.rd_m = a_rd_m; v.rd_w = a_rd_w; v.res = a_res;
      v.rwm = a_rwm; v.rww = a_rww; v.pc = a_pc; v.req = a_req; v.rdy = a_rdy;
      v.fa = a_fa; v.fb = a_fb; v.st = a_st; v.fl = a_fl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_hz(input string name, input logic [3:0] st, input logic [2:0] fl);
      chk({name, "_stall"}, {28'd0, stall_f, stall_d, stall_e, stall_m}, {28'd0, st});
      chk({name, "_flush"}, {29'd0, flush_d, flush_e, flush_w}, {29'd0, fl});
   endtask

   task automatic idle();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      result_src_e = 2'b00; reg_write_m = 0; reg_write_w = 0;
      pc_src_e = 0; dmem_req_m = 0; dmem_ready = 0;
   endtask

   task automatic set_lw();
      result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk(0,0,0,0,0,0,0, 2'b00, 0,0,0,0,0, 2'b00,2'b00, 4'b0000,3'b000);
      vecs[1]  = mk(0,0,5,0,0,5,5, 2'b00, 1,1,0,0,0, 2'b10,2'b00, 4'b0000,3'b000);
      vecs[2]  = mk(0,0,0,0,0,5,5, 2'b00, 1,1,0,0,0, 2'b00,2'b00, 4'b0000,3'b000);
      vecs[3]  = mk(0,0,5,5,0,5,5, 2'b00, 0,1,0,0,0, 2'b01,2'b01, 4'b0000,3'b000);
      vecs[4]  = mk(0,0,4,3,0,3,4, 2'b00, 1,1,0,0,0, 2'b01,2'b10, 4'b0000,3'b000);
      vecs[5]  = mk(0,0,0,6,0,0,6, 2'b00, 1,0,0,0,0, 2'b00,2'b00, 4'b0000,3'b000);
      vecs[6]  = mk(0,7,0,0,7,0,0, 2'b01, 0,0,0,0,0, 2'b00,2'b00, 4'b1100,3'b010);
      vecs[7]  = mk(7,0,0,0,7,0,0, 2'b01, 0,0,0,0,0, 2'b00,2'b00, 4'b1100,3'b010);
      vecs[8]  = mk(0,0,0,0,0,0,0, 2'b01, 0,0,0,0,0, 2'b00,2'b00, 4'b0000,3'b000);
      vecs[9]  = mk(7,0,0,0,7,0,0, 2'b00, 0,0,0,0,0, 2'b00,2'b00, 4'b0000,3'b000);
      vecs[10] = mk(7,0,0,0,7,0,0, 2'b10, 0,0,0,0,0, 2'b00,2'b00, 4'b0000,3'b000);
      vecs[11] = mk(0,0,0,0,0,0,0, 2'b00, 0,0,1,0,0, 2'b00,2'b00, 4'b0000,3'b110);
      vecs[12] = mk(7,0,0,0,7,0,0, 2'b01, 0,0,1,0,0, 2'b00,2'b00, 4'b0000,3'b110);
      vecs[13] = mk(7,0,0,0,7,0,0, 2'b01, 0,0,1,1,0, 2'b00,2'b00, 4'b1111,3'b001);
      vecs[14] = mk(7,0,0,0,7,0,0, 2'b01, 0,0,0,1,1, 2'b00,2'b00, 4'b1100,3'b010);
      vecs[15] = mk(7,0,9,0,7,9,0, 2'b01, 1,0,0,0,0, 2'b10,2'b00, 4'b1100,3'b010);

      idle();
      reset_n = 1'b0;
      rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; pc_src_e = 1'b1;
      tick();
      tick();
      #1;
      chk_hz("reset", 4'b0000, 3'b111);
      chk("reset_fa", {30'd0, forward_a_e}, 32'd0);
      chk("reset_stall_cycles", {28'd0, stall_cycles}, 32'd0);
      chk("reset_flush_count", {28'd0, flush_count}, 32'd0);
      chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
         rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e;
         rd_e = vecs[i].rd_e; rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w;
         result_src_e = vecs[i].res;
         reg_write_m = vecs[i].rwm; reg_write_w = vecs[i].rww;
         pc_src_e = vecs[i].pc; dmem_req_m = vecs[i].req; dmem_ready = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d_fa", i), {30'd0, forward_a_e}, {30'd0, vecs[i].fa});
         chk($sformatf("v%0d_fb", i), {30'd0, forward_b_e}, {30'd0, vecs[i].fb});
         chk_hz($sformatf("v%0d", i), vecs[i].st, vecs[i].fl);
      end

      @(negedge clk);
      idle();
      do_reset();

      // single load-use bubble
      set_lw();
      #1 chk_hz("lw", 4'b1100, 3'b010);
      tick();
      idle();
      #1 chk_hz("lw_after", 4'b0000, 3'b000);
      chk("lw_stall_cycles", {28'd0, stall_cycles}, 32'd1);
      chk("lw_flush_count", {28'd0, flush_count}, 32'd0);

      // taken branch
      pc_src_e = 1'b1;
      #1 chk_hz("br", 4'b0000, 3'b110);
      tick();
      pc_src_e = 1'b0;
      chk("br_flush_count", {28'd0, flush_count}, 32'd1);
      chk("br_stall_cycles", {28'd0, stall_cycles}, 32'd1);

      // three wait cycles, with a branch masked during the wait
      dmem_req_m = 1'b1; dmem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pc_src_e = (k >= 1);
         #1 chk_hz($sformatf("mem%0d", k), 4'b1111, 3'b001);
         tick();
      end
      dmem_ready = 1'b1;
      #1 chk_hz("mem_done_br", 4'b0000, 3'b110);
      chk("mem_stall_cycles", {28'd0, stall_cycles}, 32'd4);
      chk("mem_masked_br", {28'd0, flush_count}, 32'd1);
      tick();
      idle();
      chk("mem_br_count", {28'd0, flush_count}, 32'd2);
      chk("mem_no_timeout", {31'd0, mem_timeout}, 32'd0);

      // saturation of both counters
      set_lw();
      repeat (14) tick();
      idle();
      chk("sat_stall_cycles", {28'd0, stall_cycles}, 32'd15);
      pc_src_e = 1'b1;
      repeat (16) tick();
      pc_src_e = 1'b0;
      chk("sat_flush_count", {28'd0, flush_count}, 32'd15);

      // reset in the middle of a memory wait
      dmem_req_m = 1'b1; dmem_ready = 1'b0;
      tick();
      tick();
      reset_n = 1'b0; pc_src_e = 1'b1;
      #1 chk_hz("rst_wait", 4'b0000, 3'b111);
      tick();
      chk("rst_wait_stall_cycles", {28'd0, stall_cycles}, 32'd0);
      chk("rst_wait_flush_count", {28'd0, flush_count}, 32'd0);
      reset_n = 1'b1; pc_src_e = 1'b0; dmem_req_m = 1'b0;
      #1 chk_hz("rst_wait_after", 4'b0000, 3'b000);
      dmem_req_m = 1'b1;
      repeat (3) tick();
      dmem_ready = 1'b1;
      tick();
      idle();
      chk("rst_wait_no_timeout", {31'd0, mem_timeout}, 32'd0);
      chk("rst_wait_restall", {28'd0, stall_cycles}, 32'd3);

      // timeout into the absorbing error state
      dmem_req_m = 1'b1; dmem_ready = 1'b0;
      repeat (3) tick();
      chk("to_before", {31'd0, mem_timeout}, 32'd0);
      tick();
      chk("to_set", {31'd0, mem_timeout}, 32'd1);
      dmem_req_m = 1'b0; pc_src_e = 1'b1;
      #1 chk_hz("err", 4'b1111, 3'b001);
      tick();
      chk("to_sticky", {31'd0, mem_timeout}, 32'd1);
      chk("err_flush_count", {28'd0, flush_count}, 32'd0);
      chk("err_stall_cycles", {28'd0, stall_cycles}, 32'd8);
      idle();
      #1 chk_hz("err_hold", 4'b1111, 3'b001);
      do_reset();
      #1 chk_hz("err_cleared", 4'b0000, 3'b000);
      chk("err_cleared_timeout", {31'd0, mem_timeout}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
